// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data memory.
//   - mem_op_e            : access type encodings (loads 000-100, stores 101-111)
//   - DEPTH_WORDS_DEFAULT : default number of 32-bit words
//   - is_store/is_half/is_byte : op decode helpers
package mem_pkg;

    localparam int unsigned DEPTH_WORDS_DEFAULT = 3072;

    typedef enum logic [2:0] {
        MEM_LW  = 3'b000,
        MEM_LH  = 3'b001,
        MEM_LHU = 3'b010,
        MEM_LB  = 3'b011,
        MEM_LBU = 3'b100,
        MEM_SW  = 3'b101,
        MEM_SH  = 3'b110,
        MEM_SB  = 3'b111
    } mem_op_e;

    function automatic logic is_store(input logic [2:0] op);
        return (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
    endfunction

    function automatic logic is_half(input logic [2:0] op);
        return (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
    endfunction

    function automatic logic is_byte(input logic [2:0] op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_SB);
    endfunction

endpackage

// File: rtl/load_ext.sv
// load_ext: selects the addressed lane of a word and sign/zero-extends it.
//   word_i     : full 32-bit word read from the array
//   byte_sel_i : addr[1:0], picks the byte (or halfword via bit 1)
//   mem_op_i   : access type; store ops produce 0
//   rdata_o    : extended load result
module load_ext
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  byte_sel_i,
    input  logic [2:0]  mem_op_i,
    output logic [31:0] rdata_o
);

    logic [15:0] half;
    logic [7:0]  byte_lane;

    always_comb begin
        half      = byte_sel_i[1] ? word_i[31:16] : word_i[15:0];
        byte_lane = word_i[{byte_sel_i, 3'b000} +: 8];
        rdata_o   = '0;
        case (mem_op_i)
            MEM_LW:  rdata_o = word_i;
            MEM_LH:  rdata_o = {{16{half[15]}}, half};
            MEM_LHU: rdata_o = {16'h0000, half};
            MEM_LB:  rdata_o = {{24{byte_lane[7]}}, byte_lane};
            MEM_LBU: rdata_o = {24'h000000, byte_lane};
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// data_mem: word-organised data memory with byte/halfword/word access.
//   clk      : write clock (stores land on the rising edge)
//   reset_n  : async active-low reset, clears the whole array
//   mem_en   : access valid this cycle
//   mem_op   : access type (see mem_pkg::mem_op_e)
//   addr     : byte address (ALU result)
//   wdata    : store data (SH uses [15:0], SB uses [7:0])
//   rdata    : combinational, extended load result; 0 for stores/errors/reset
//   addr_err : combinational misaligned-or-out-of-range flag
module data_mem
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_en,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_err
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Range check is done on 33 bits so no address above the array can wrap into it.
    localparam logic [32:0] AddrLimit = {1'b0, 32'(DEPTH_WORDS)} << 2;

    // Whole array held as one packed vector so reset can clear it in a single assignment.
    logic [DEPTH_WORDS-1:0][31:0] mem_q;

    logic            out_of_range;
    logic            misaligned;
    logic            store_en;
    logic            load_en;
    logic [IdxW-1:0] word_idx;
    logic [31:0]     cur_word;
    logic [31:0]     merged_d;
    logic [31:0]     ext_word;

    assign word_idx = addr[IdxW+1:2];

    always_comb begin
        out_of_range = ({1'b0, addr} >= AddrLimit);
        misaligned   = 1'b0;
        if ((mem_op == MEM_LW) || (mem_op == MEM_SW)) begin
            misaligned = (addr[1:0] != 2'b00);
        end else if (is_half(mem_op)) begin
            misaligned = addr[0];
        end
        addr_err = mem_en & (misaligned | out_of_range);
    end

    // Out-of-range indices never touch the array.
    assign cur_word = out_of_range ? '0 : mem_q[word_idx];

    // Lane merge: only the addressed byte/halfword of the current word is replaced.
    always_comb begin
        merged_d = cur_word;
        if (mem_op == MEM_SW) begin
            merged_d = wdata;
        end else if (is_half(mem_op)) begin
            merged_d[{addr[1], 4'b0000} +: 16] = wdata[15:0];
        end else if (is_byte(mem_op)) begin
            merged_d[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
        end
    end

    assign store_en = mem_en & is_store(mem_op) & ~addr_err;
    assign load_en  = reset_n & mem_en & ~is_store(mem_op) & ~addr_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '0;
        end else if (store_en) begin
            mem_q[word_idx] <= merged_d;
        end
    end

    load_ext u_load_ext (
        .word_i     (cur_word),
        .byte_sel_i (addr[1:0]),
        .mem_op_i   (mem_op),
        .rdata_o    (ext_word)
    );

    assign rdata = load_en ? ext_word : '0;

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed self-checking bench for data_mem.
module tb_data_mem;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_en;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mem_en   (mem_en),
        .mem_op   (mem_op),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .addr_err (addr_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply an access just after the falling edge; a store commits at the next rising edge.
    task automatic drive(input logic en, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d);
        @(negedge clk);
        mem_en = en;
        mem_op = op;
        addr   = a;
        wdata  = d;
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        mem_en  = 1'b0;
        mem_op  = OP_LW;
        addr    = '0;
        wdata   = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Basic word store/load and reset clear
        drive(1'b1, OP_LW, 32'h0, 32'h0);
        check("reset_lw0", rdata, 32'h0);
        drive(1'b1, OP_SW, 32'h0, 32'h8765_4321);
        check("sw0_err", {31'b0, addr_err}, 32'h0);
        check("sw0_rdata", rdata, 32'h0);
        drive(1'b1, OP_LW, 32'h0, 32'h0);
        check("lw0", rdata, 32'h8765_4321);
        reset_n = 1'b0;
        #1;
        check("lw0_in_reset", rdata, 32'h0);
        drive(1'b1, OP_LH, 32'h3, 32'h0);
        check("err_in_reset", {31'b0, addr_err}, 32'h1);
        reset_n = 1'b1;
        drive(1'b1, OP_LW, 32'h0, 32'h0);
        check("lw0_after_reset", rdata, 32'h0);

        // Lane merge
        drive(1'b1, OP_SW, 32'h4, 32'h0000_0000);
        drive(1'b1, OP_SB, 32'h5, 32'h0000_00AB);
        drive(1'b1, OP_SH, 32'h6, 32'h0000_F00D);
        drive(1'b1, OP_LW, 32'h4, 32'h0);
        check("merge_lw4", rdata, 32'hF00D_AB00);

        // Extension
        drive(1'b1, OP_LB, 32'h5, 32'h0);
        check("lb5", rdata, 32'hFFFF_FFAB);
        drive(1'b1, OP_LBU, 32'h5, 32'h0);
        check("lbu5", rdata, 32'h0000_00AB);
        drive(1'b1, OP_LH, 32'h6, 32'h0);
        check("lh6", rdata, 32'hFFFF_F00D);
        drive(1'b1, OP_LHU, 32'h6, 32'h0);
        check("lhu6", rdata, 32'h0000_F00D);
        drive(1'b1, OP_LH, 32'h4, 32'h0);
        check("lh4", rdata, 32'hFFFF_AB00);
        drive(1'b1, OP_LB, 32'h4, 32'h0);
        check("lb4", rdata, 32'h0000_0000);

        // Misalignment
        drive(1'b1, OP_SW, 32'h6, 32'hDEAD_BEEF);
        check("sw6_err", {31'b0, addr_err}, 32'h1);
        drive(1'b1, OP_LW, 32'h4, 32'h0);
        check("lw4_err", {31'b0, addr_err}, 32'h0);
        check("lw4_unchanged", rdata, 32'hF00D_AB00);
        drive(1'b1, OP_LH, 32'h3, 32'h0);
        check("lh3_err", {31'b0, addr_err}, 32'h1);
        check("lh3_rdata", rdata, 32'h0);
        drive(1'b1, OP_LW, 32'h2, 32'h0);
        check("lw2_err", {31'b0, addr_err}, 32'h1);
        check("lw2_rdata", rdata, 32'h0);
        drive(1'b1, OP_SB, 32'h3, 32'h0000_0077);
        check("sb3_err", {31'b0, addr_err}, 32'h0);
        drive(1'b1, OP_LBU, 32'h3, 32'h0);
        check("lbu3", rdata, 32'h0000_0077);

        // Range boundaries, no wrap
        drive(1'b1, OP_SW, 32'h0, 32'hA5A5_A5A5);
        drive(1'b1, OP_SW, 32'h2FFC, 32'h1234_5678);
        check("sw_top_err", {31'b0, addr_err}, 32'h0);
        drive(1'b1, OP_LW, 32'h2FFC, 32'h0);
        check("lw_top", rdata, 32'h1234_5678);
        drive(1'b1, OP_SW, 32'h3000, 32'hCAFE_0000);
        check("sw_3000_err", {31'b0, addr_err}, 32'h1);
        drive(1'b1, OP_SW, 32'h0001_0000, 32'h5555_5555);
        check("sw_10000_err", {31'b0, addr_err}, 32'h1);
        drive(1'b1, OP_LW, 32'hFFFF_FFFC, 32'h0);
        check("lw_fffc_err", {31'b0, addr_err}, 32'h1);
        check("lw_fffc_rdata", rdata, 32'h0);
        drive(1'b1, OP_LW, 32'h0, 32'h0);
        check("lw0_no_wrap", rdata, 32'hA5A5_A5A5);

        // mem_en low: no write, outputs quiet
        drive(1'b0, OP_SW, 32'h0, 32'hFFFF_FFFF);
        check("dis_err", {31'b0, addr_err}, 32'h0);
        drive(1'b0, OP_LW, 32'h3, 32'h0);
        check("dis_misaligned_err", {31'b0, addr_err}, 32'h0);
        check("dis_rdata", rdata, 32'h0);
        drive(1'b1, OP_LW, 32'h0, 32'h0);
        check("lw0_after_dis", rdata, 32'hA5A5_A5A5);

        // Read-during-write: old value before the edge, new one after
        drive(1'b1, OP_SW, 32'h8, 32'h1111_1111);
        drive(1'b1, OP_LW, 32'h8, 32'h0);
        check("rdw_before", rdata, 32'h1111_1111);
        mem_op = OP_SW;
        wdata  = 32'h2222_2222;
        @(posedge clk);
        #1;
        mem_op = OP_LW;
        #1;
        check("rdw_after", rdata, 32'h2222_2222);

        // Reset across a pending store aborts it
        drive(1'b1, OP_SW, 32'h8, 32'h3333_3333);
        #2;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        mem_en  = 1'b0;
        reset_n = 1'b1;
        drive(1'b1, OP_LW, 32'h8, 32'h0);
        check("abort_lw8", rdata, 32'h0);
        drive(1'b1, OP_LW, 32'h2FFC, 32'h0);
        check("abort_lw_top", rdata, 32'h0);
        drive(1'b1, OP_SW, 32'h8, 32'h4444_4444);
        drive(1'b1, OP_LW, 32'h8, 32'h0);
        check("post_reset_sw", rdata, 32'h4444_4444);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
